fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the immediate generator and decoder.
- Holds the fetch PC and issues single-outstanding word requests to instruction memory via a valid/ready request channel and a valid response channel.
- Presents each fetched 32-bit Instruction and its PC to decode with a valid/ready handshake.
- Accepts redirects (taken branch or jump target) from execute, and counts retired fetches.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding word fetch feeding decode.
// Ports: clk/reset, Imem req (valid/ready/addr), Imem resp (valid/data),
// decode out (Instruction/InstrPC/InstrValid/InstrReady), Redirect/RedirectPC,
// AddrFault (sticky misaligned redirect), FetchCount (decode handshakes).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [31:0] ImemAddr,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        AddrFault,
  output logic [31:0] FetchCount
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        drop;
  logic        bad_redir;
  logic        take;

  assign ImemAddr  = fetch_pc;
  assign bad_redir = Redirect && (RedirectPC[1:0] != 2'b00);
  assign take      = InstrValid && InstrReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      drop         <= 1'b0;
      ImemReqValid <= 1'b0;
      InstrValid   <= 1'b0;
      Instruction  <= NOP_INSTR;
      InstrPC      <= 32'h0;
      AddrFault    <= 1'b0;
      FetchCount   <= 32'h0;
    end else if (state != FAULT && bad_redir) begin
      // misaligned target: park until reset
      state        <= FAULT;
      AddrFault    <= 1'b1;
      drop         <= 1'b0;
      ImemReqValid <= 1'b0;
      InstrValid   <= 1'b0;
      Instruction  <= NOP_INSTR;
    end else begin
      unique case (state)
        IDLE: begin
          if (Redirect) fetch_pc <= RedirectPC;
          state        <= REQ;
          ImemReqValid <= 1'b1;
        end
        REQ: begin
          if (Redirect) fetch_pc <= RedirectPC;
          if (ImemReqReady) begin
            // old address was accepted; its data is stale on redirect
            drop         <= Redirect;
            state        <= WAIT;
            ImemReqValid <= 1'b0;
          end
        end
        WAIT: begin
          if (Redirect) begin
            fetch_pc <= RedirectPC;
            if (ImemRespValid) begin
              drop         <= 1'b0;
              state        <= REQ;
              ImemReqValid <= 1'b1;
            end else begin
              drop <= 1'b1;
            end
          end else if (ImemRespValid) begin
            if (drop) begin
              drop         <= 1'b0;
              state        <= REQ;
              ImemReqValid <= 1'b1;
            end else begin
              Instruction <= ImemRespData;
              InstrPC     <= fetch_pc;
              InstrValid  <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (take) FetchCount <= FetchCount + 32'd1;
          if (Redirect) fetch_pc <= RedirectPC;
          else if (take) fetch_pc <= fetch_pc + 32'd4;
          if (Redirect || take) begin
            InstrValid   <= 1'b0;
            Instruction  <= NOP_INSTR;
            state        <= REQ;
            ImemReqValid <= 1'b1;
          end
        end
        FAULT: begin
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// Drives inputs #1 after posedge; an optional memory model responds next cycle.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [31:0] ImemAddr;
  logic        ImemRespValid;
  logic [31:0] ImemRespData;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        AddrFault;
  logic [31:0] FetchCount;

  int n_tests = 0;
  int n_fail  = 0;
  bit auto_resp = 1'b0;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .ImemReqValid (ImemReqValid),
    .ImemReqReady (ImemReqReady),
    .ImemAddr     (ImemAddr),
    .ImemRespValid(ImemRespValid),
    .ImemRespData (ImemRespData),
    .Instruction  (Instruction),
    .InstrPC      (InstrPC),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .Redirect     (Redirect),
    .RedirectPC   (RedirectPC),
    .AddrFault    (AddrFault),
    .FetchCount   (FetchCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[23:0], 8'h13};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // one clock; memory model answers an accepted request on the next cycle
  task automatic cyc();
    logic        acc;
    logic [31:0] a;
    acc = ImemReqValid && ImemReqReady;
    a   = ImemAddr;
    @(posedge clk);
    #1;
    if (auto_resp) begin
      ImemRespValid = acc;
      ImemRespData  = acc ? mem_word(a) : 32'h0;
    end
  endtask

  initial begin
    reset = 1'b1;
    ImemReqReady = 1'b1;
    ImemRespValid = 1'b0;
    ImemRespData = 32'h0;
    InstrReady = 1'b0;
    Redirect = 1'b0;
    RedirectPC = 32'h0;
    cyc();
    cyc();
    check("rst_reqv", {31'h0, ImemReqValid}, 32'd0);
    check("rst_iv", {31'h0, InstrValid}, 32'd0);
    check("rst_instr", Instruction, NOP);
    check("rst_ipc", InstrPC, 32'h0);
    check("rst_flt", {31'h0, AddrFault}, 32'd0);
    check("rst_cnt", FetchCount, 32'h0);

    // basic streaming
    reset = 1'b0;
    auto_resp = 1'b1;
    InstrReady = 1'b1;
    cyc();
    check("req_v", {31'h0, ImemReqValid}, 32'd1);
    check("req_addr0", ImemAddr, 32'h0);
    cyc();
    check("wait_v", {31'h0, ImemReqValid}, 32'd0);
    check("wait_iv", {31'h0, InstrValid}, 32'd0);
    cyc();
    check("lat_iv", {31'h0, InstrValid}, 32'd1);
    check("lat_ipc", InstrPC, 32'h0);
    check("lat_instr", Instruction, 32'h0050_0093);
    cyc();
    check("cnt1", FetchCount, 32'd1);
    check("addr4", ImemAddr, 32'h4);
    check("req_v2", {31'h0, ImemReqValid}, 32'd1);
    repeat (6) cyc();
    check("cnt3", FetchCount, 32'd3);
    check("addr12", ImemAddr, 32'hC);

    // decode stall
    InstrReady = 1'b0;
    cyc();
    cyc();
    check("st_iv", {31'h0, InstrValid}, 32'd1);
    check("st_ipc", InstrPC, 32'hC);
    check("st_instr", Instruction, 32'h0000_0C13);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("st_hold_iv", {31'h0, InstrValid}, 32'd1);
      check("st_hold_ipc", InstrPC, 32'hC);
      check("st_hold_ins", Instruction, 32'h0000_0C13);
      check("st_hold_req", {31'h0, ImemReqValid}, 32'd0);
      check("st_hold_cnt", FetchCount, 32'd3);
    end
    InstrReady = 1'b1;
    cyc();
    check("st_cnt4", FetchCount, 32'd4);
    check("st_addr16", ImemAddr, 32'h10);

    // redirect in WAIT, response two cycles later
    auto_resp = 1'b0;
    cyc();
    Redirect = 1'b1;
    RedirectPC = 32'h100;
    cyc();
    Redirect = 1'b0;
    cyc();
    check("rw_iv", {31'h0, InstrValid}, 32'd0);
    check("rw_req", {31'h0, ImemReqValid}, 32'd0);
    ImemRespValid = 1'b1;
    ImemRespData = 32'hDEAD_BEEF;
    cyc();
    ImemRespValid = 1'b0;
    check("rw_drop_iv", {31'h0, InstrValid}, 32'd0);
    check("rw_req2", {31'h0, ImemReqValid}, 32'd1);
    check("rw_addr", ImemAddr, 32'h100);
    auto_resp = 1'b1;
    cyc();
    cyc();
    check("rw_iv2", {31'h0, InstrValid}, 32'd1);
    check("rw_ipc", InstrPC, 32'h100);
    check("rw_instr", Instruction, 32'h0001_0013);

    // handshake plus redirect in HOLD
    Redirect = 1'b1;
    RedirectPC = 32'h8;
    cyc();
    Redirect = 1'b0;
    check("hr_cnt", FetchCount, 32'd5);
    check("hr_addr", ImemAddr, 32'h8);

    // redirect on request acceptance
    auto_resp = 1'b0;
    Redirect = 1'b1;
    RedirectPC = 32'h200;
    cyc();
    Redirect = 1'b0;
    check("ra_addr", ImemAddr, 32'h200);
    check("ra_req", {31'h0, ImemReqValid}, 32'd0);
    ImemRespValid = 1'b1;
    ImemRespData = 32'h0000_0813;
    cyc();
    ImemRespValid = 1'b0;
    check("ra_iv", {31'h0, InstrValid}, 32'd0);
    check("ra_req2", {31'h0, ImemReqValid}, 32'd1);
    check("ra_addr2", ImemAddr, 32'h200);
    cyc();
    Redirect = 1'b1;
    RedirectPC = 32'h300;
    ImemRespValid = 1'b1;
    cyc();
    Redirect = 1'b0;
    ImemRespValid = 1'b0;
    check("rr_iv", {31'h0, InstrValid}, 32'd0);
    check("rr_req", {31'h0, ImemReqValid}, 32'd1);
    check("rr_addr", ImemAddr, 32'h300);
    check("rr_cnt", FetchCount, 32'd5);

    // PC wrap
    ImemReqReady = 1'b0;
    Redirect = 1'b1;
    RedirectPC = 32'hFFFF_FFFC;
    cyc();
    Redirect = 1'b0;
    check("wr_addr", ImemAddr, 32'hFFFF_FFFC);
    check("wr_req", {31'h0, ImemReqValid}, 32'd1);
    ImemReqReady = 1'b1;
    auto_resp = 1'b1;
    cyc();
    cyc();
    check("wr_ipc", InstrPC, 32'hFFFF_FFFC);
    cyc();
    check("wr_addr0", ImemAddr, 32'h0);
    check("wr_cnt", FetchCount, 32'd6);

    // reset while in HOLD
    InstrReady = 1'b0;
    cyc();
    cyc();
    check("rh_iv", {31'h0, InstrValid}, 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rh_iv0", {31'h0, InstrValid}, 32'd0);
    check("rh_instr", Instruction, NOP);
    check("rh_cnt", FetchCount, 32'h0);
    check("rh_ipc", InstrPC, 32'h0);

    // misaligned redirect
    auto_resp = 1'b0;
    cyc();
    Redirect = 1'b1;
    RedirectPC = 32'h102;
    cyc();
    check("ft_flag", {31'h0, AddrFault}, 32'd1);
    check("ft_req", {31'h0, ImemReqValid}, 32'd0);
    RedirectPC = 32'h400;
    ImemRespValid = 1'b1;
    InstrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("ft_req_q", {31'h0, ImemReqValid}, 32'd0);
      check("ft_iv_q", {31'h0, InstrValid}, 32'd0);
      check("ft_flag_q", {31'h0, AddrFault}, 32'd1);
    end
    Redirect = 1'b0;
    ImemRespValid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("ft_clr", {31'h0, AddrFault}, 32'd0);
    cyc();
    check("ft_req_rs", {31'h0, ImemReqValid}, 32'd1);
    check("ft_addr_rs", ImemAddr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
